// File: rtl/regfile_mp_clr.sv
// Multi-read-port integer register file with optional write-to-read bypass.
// After reset a sequencer zeroes registers 1..NREGS-1 while busy is high; register 0 always reads zero.
module regfile_mp_clr #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              reg_wrW,
    input  logic [$clog2(NREGS)-1:0]          waddrW,
    input  logic [XLEN-1:0]                   wdata,
    input  logic [NRD*$clog2(NREGS)-1:0]      raddr,
    output logic [NRD*XLEN-1:0]               rdata,
    output logic                              busy
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              arr_we;
    logic [AW-1:0]     arr_wa;
    logic [XLEN-1:0]   arr_wd;

    // Next-state logic and the single array write port shared by clear and writeback.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        arr_we  = 1'b0;
        arr_wa  = '0;
        arr_wd  = '0;
        if (rst) begin
            state_d = CLEAR;
            idx_d   = AW'(1);
        end else begin
            case (state_q)
                CLEAR: begin
                    arr_we = 1'b1;
                    arr_wa = idx_q;
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
                RUN: begin
                    arr_we = reg_wrW && (waddrW != '0);
                    arr_wa = waddrW;
                    arr_wd = wdata;
                end
                default: begin
                    state_d = CLEAR;
                    idx_d   = AW'(1);
                end
            endcase
        end
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        idx_q   <= idx_d;
        busy_q  <= busy_d;
        if (arr_we) begin
            regs_q[arr_wa] <= arr_wd;
        end
    end

    assign busy = busy_q;

    // Asynchronous read ports; zero while clearing or when addressing register 0.
    always_comb begin
        logic [AW-1:0] ra;
        ra    = '0;
        rdata = '0;
        for (int p = 0; p < int'(NRD); p++) begin
            ra = raddr[p*AW +: AW];
            if ((state_q == RUN) && (ra != '0)) begin
                if ((BYPASS != 0) && reg_wrW && (waddrW == ra)) begin
                    rdata[p*XLEN +: XLEN] = wdata;
                end else begin
                    rdata[p*XLEN +: XLEN] = regs_q[ra];
                end
            end
        end
    end

endmodule
